// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: exceptions, bus waits, load-use, branch flush.
// Optional stall-cycle performance counter enabled by defining PERF_CNT_EN.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   S_RUN      | normal issue; resolves exception > bus wait > load-use > branch
//   S_MEM_WAIT | pipeline frozen behind an unacknowledged memory access
//   S_EXC_HOLD | fetch bubbles after an exception redirect
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int EXC_HOLD    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEXMemRead,
  input  logic [5:0]  IDEXRegDest,
  input  logic [5:0]  IFIDRs,
  input  logic [5:0]  IFIDRt,
  input  logic        BranchFlush,
  input  logic        MemReq,
  input  logic        MemAck,
  input  logic        ExcSyscall,
  input  logic        ExcEret,
  output logic        PCWriteEN,
  output logic [1:0]  PCSel,
  output logic        ExcCommit,
  output logic        IFIDWE,
  output logic        IFIDClr,
  output logic        IDEXWE,
  output logic        IDEXClr,
  output logic        EXMEMWE,
  output logic        EXMEMClr,
  output logic        MEMWBWE,
  output logic        MEMWBClr,
  output logic        BusTimeout,
  output logic [31:0] StallCnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_EXC_HOLD} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt, wait_inc;
  logic [3:0]    hold_cnt, hold_nxt;
  logic          load_use, do_freeze, do_haz;

  assign wait_inc = wait_cnt + 1'b1;
  assign load_use = IDEXMemRead && (IDEXRegDest != 6'd0) &&
                    ((IDEXRegDest == IFIDRs) || (IDEXRegDest == IFIDRt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    hold_nxt   = hold_cnt;
    PCWriteEN  = 1'b1;
    PCSel      = 2'b00;
    ExcCommit  = 1'b0;
    IFIDWE     = 1'b1;
    IFIDClr    = 1'b0;
    IDEXWE     = 1'b1;
    IDEXClr    = 1'b0;
    EXMEMWE    = 1'b1;
    EXMEMClr   = 1'b0;
    MEMWBWE    = 1'b1;
    MEMWBClr   = 1'b0;
    BusTimeout = 1'b0;
    do_freeze  = 1'b0;
    do_haz     = 1'b0;

    case (state)
      S_RUN: begin
        if (ExcSyscall || ExcEret) begin
          ExcCommit = 1'b1;
          PCSel     = ExcSyscall ? 2'b01 : 2'b10;
          IFIDClr   = 1'b1;
          IDEXClr   = 1'b1;
          EXMEMClr  = 1'b1;
          MEMWBClr  = 1'b1;
          if (EXC_HOLD == 0) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_EXC_HOLD;
            hold_nxt  = 4'(EXC_HOLD);
          end
        end else if (MemReq && !MemAck) begin
          do_freeze = 1'b1;
          wait_nxt  = WW'(1);
          state_nxt = S_MEM_WAIT;
        end else begin
          do_haz = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // an ack landing on the timeout cycle wins and suppresses the pulse
        if (MemAck || (wait_inc >= WW'(MEM_TIMEOUT))) begin
          BusTimeout = !MemAck;
          wait_nxt   = '0;
          state_nxt  = S_RUN;
          do_haz     = 1'b1;
        end else begin
          do_freeze = 1'b1;
          wait_nxt  = wait_inc;
        end
      end
      S_EXC_HOLD: begin
        PCWriteEN = 1'b0;
        IFIDClr   = 1'b1;
        if (hold_cnt <= 4'd1) begin
          hold_nxt  = '0;
          state_nxt = S_RUN;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      default: state_nxt = S_RUN;
    endcase

    if (do_freeze) begin
      PCWriteEN = 1'b0;
      IFIDWE    = 1'b0;
      IDEXWE    = 1'b0;
      EXMEMWE   = 1'b0;
      MEMWBClr  = 1'b1;
    end

    if (do_haz) begin
      if (load_use) begin
        PCWriteEN = 1'b0;
        IFIDWE    = 1'b0;
        IDEXClr   = 1'b1;
      end else if (BranchFlush) begin
        IFIDClr = 1'b1;
      end
    end

    if (!rst) begin
      PCWriteEN  = 1'b0;
      PCSel      = 2'b00;
      ExcCommit  = 1'b0;
      IFIDWE     = 1'b0;
      IFIDClr    = 1'b1;
      IDEXWE     = 1'b0;
      IDEXClr    = 1'b1;
      EXMEMWE    = 1'b0;
      EXMEMClr   = 1'b1;
      MEMWBWE    = 1'b0;
      MEMWBClr   = 1'b1;
      BusTimeout = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      StallCnt <= '0;
    else if (!PCWriteEN && (StallCnt != 32'hFFFF_FFFF))
      StallCnt <= StallCnt + 32'd1;
  end
`else
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: two parameterisations driven in lockstep,
// compared every cycle against a cycle-count model plus literal spot checks.
module tb_pipeline_hazard_ctrl;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic IDEXMemRead, BranchFlush, MemReq, MemAck, ExcSyscall, ExcEret;
  logic [5:0] IDEXRegDest, IFIDRs, IFIDRt;

  logic a_pcwe, a_exc, a_ifwe, a_ifclr, a_idwe, a_idclr, a_exwe, a_exclr, a_mwwe, a_mwclr, a_bt;
  logic b_pcwe, b_exc, b_ifwe, b_ifclr, b_idwe, b_idclr, b_exwe, b_exclr, b_mwwe, b_mwclr, b_bt;
  logic [1:0]  a_sel, b_sel;
  logic [31:0] a_stall, b_stall;

  int errors = 0;
  int checks = 0;

  int TO[2] = '{4, 6};
  int EH[2] = '{1, 3};
  bit m_wait[2];
  int m_waited[2];
  int m_hold[2];
  int m_stall[2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .EXC_HOLD(1)) dut_a (
    .clk(clk), .rst(rst), .IDEXMemRead(IDEXMemRead), .IDEXRegDest(IDEXRegDest),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .BranchFlush(BranchFlush), .MemReq(MemReq),
    .MemAck(MemAck), .ExcSyscall(ExcSyscall), .ExcEret(ExcEret),
    .PCWriteEN(a_pcwe), .PCSel(a_sel), .ExcCommit(a_exc), .IFIDWE(a_ifwe), .IFIDClr(a_ifclr),
    .IDEXWE(a_idwe), .IDEXClr(a_idclr), .EXMEMWE(a_exwe), .EXMEMClr(a_exclr),
    .MEMWBWE(a_mwwe), .MEMWBClr(a_mwclr), .BusTimeout(a_bt), .StallCnt(a_stall));

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(6), .EXC_HOLD(3)) dut_b (
    .clk(clk), .rst(rst), .IDEXMemRead(IDEXMemRead), .IDEXRegDest(IDEXRegDest),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .BranchFlush(BranchFlush), .MemReq(MemReq),
    .MemAck(MemAck), .ExcSyscall(ExcSyscall), .ExcEret(ExcEret),
    .PCWriteEN(b_pcwe), .PCSel(b_sel), .ExcCommit(b_exc), .IFIDWE(b_ifwe), .IFIDClr(b_ifclr),
    .IDEXWE(b_idwe), .IDEXClr(b_idclr), .EXMEMWE(b_exwe), .EXMEMClr(b_exclr),
    .MEMWBWE(b_mwwe), .MEMWBClr(b_mwclr), .BusTimeout(b_bt), .StallCnt(b_stall));

  logic [12:0] va, vb;
  assign va = {a_pcwe, a_sel, a_exc, a_ifwe, a_ifclr, a_idwe, a_idclr, a_exwe, a_exclr, a_mwwe, a_mwclr, a_bt};
  assign vb = {b_pcwe, b_sel, b_exc, b_ifwe, b_ifclr, b_idwe, b_idclr, b_exwe, b_exclr, b_mwwe, b_mwclr, b_bt};

  // model state: in-wait flag, wait cycles elapsed, fetch-bubble cycles still owed
  function automatic void model_eval(input int i, output logic [12:0] o, output bit nw,
                                     output int nwd, output int nh);
    int n;
    bit haz, lu;
    logic pcwe, exc, to;
    logic [1:0] sel;
    logic [3:0] we, clr;
    nw = m_wait[i]; nwd = m_waited[i]; nh = m_hold[i];
    haz = 1'b0;
    lu = IDEXMemRead && IDEXRegDest != 0 && (IDEXRegDest == IFIDRs || IDEXRegDest == IFIDRt);
    if (!rst) begin
      pcwe = 0; sel = 0; exc = 0; we = 4'h0; clr = 4'hF; to = 0;
      nw = 0; nwd = 0; nh = 0;
    end else begin
      pcwe = 1; sel = 0; exc = 0; we = 4'hF; clr = 4'h0; to = 0;
      if (m_hold[i] > 0) begin
        pcwe = 0; clr[3] = 1; nh = m_hold[i] - 1;
      end else if (m_wait[i]) begin
        n = m_waited[i] + 1;
        if (MemAck) begin
          nw = 0; nwd = 0; haz = 1;
        end else if (n >= TO[i]) begin
          to = 1; nw = 0; nwd = 0; haz = 1;
        end else begin
          pcwe = 0; we[3:1] = 3'b000; clr[0] = 1; nwd = n;
        end
      end else if (ExcSyscall || ExcEret) begin
        exc = 1; sel = ExcSyscall ? 2'd1 : 2'd2; clr = 4'hF; nh = EH[i];
      end else if (MemReq && !MemAck) begin
        pcwe = 0; we[3:1] = 3'b000; clr[0] = 1; nw = 1; nwd = 1;
      end else begin
        haz = 1;
      end
      if (haz) begin
        if (lu) begin
          pcwe = 0; we[3] = 0; clr[2] = 1;
        end else if (BranchFlush) begin
          clr[3] = 1;
        end
      end
    end
    o = {pcwe, sel, exc, we[3], clr[3], we[2], clr[2], we[1], clr[1], we[0], clr[0], to};
  endfunction

  always @(posedge clk) begin
    logic [12:0] o;
    bit nw;
    int nwd, nh;
    for (int i = 0; i < 2; i++) begin
      model_eval(i, o, nw, nwd, nh);
      m_wait[i]   <= nw;
      m_waited[i] <= nwd;
      m_hold[i]   <= nh;
      if (!rst)
        m_stall[i] <= 0;
      else if (!o[12])
        m_stall[i] <= m_stall[i] + 1;
    end
  end

  always @(negedge clk) begin
    logic [12:0] o, act;
    logic [31:0] es, as;
    bit nw;
    int nwd, nh;
    for (int i = 0; i < 2; i++) begin
      model_eval(i, o, nw, nwd, nh);
      act = (i == 0) ? va : vb;
      as  = (i == 0) ? a_stall : b_stall;
      es  = (PERF && rst) ? 32'(m_stall[i]) : 32'd0;
      checks++;
      if (act !== o) begin
        errors++;
        $display("FAIL dut%0d_outs t=%0t: got %b expected %b", i, $time, act, o);
      end
      checks++;
      if (as !== es) begin
        errors++;
        $display("FAIL dut%0d_stallcnt t=%0t: got %0d expected %0d", i, $time, as, es);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [5:0] dest, input logic [5:0] rs,
                       input logic [5:0] rt, input logic bf, input logic mreq,
                       input logic mack, input logic sys, input logic eret);
    @(posedge clk);
    #1;
    IDEXMemRead = rd; IDEXRegDest = dest; IFIDRs = rs; IFIDRt = rt;
    BranchFlush = bf; MemReq = mreq; MemAck = mack; ExcSyscall = sys; ExcEret = eret;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    IDEXMemRead = 0; IDEXRegDest = 0; IFIDRs = 0; IFIDRt = 0;
    BranchFlush = 0; MemReq = 0; MemAck = 0; ExcSyscall = 0; ExcEret = 0;
    #1 rst = 1'b0;
    #2;
    lit("rst_pcwe", 32'(a_pcwe), 0);
    lit("rst_clr", 32'({a_ifclr, a_idclr, a_exclr, a_mwclr}), 32'hF);
    lit("rst_we", 32'({a_ifwe, a_idwe, a_exwe, a_mwwe}), 0);
    @(posedge clk); #1 rst = 1'b1;
    idle(); idle();

    // load-use on rs, then recovery
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0); #2;
    lit("lu_pcwe", 32'(a_pcwe), 0);
    lit("lu_ifidwe", 32'(a_ifwe), 0);
    lit("lu_idexclr", 32'(a_idclr), 1);
    lit("lu_exmemwe", 32'(a_exwe), 1);
    idle(); #2;
    lit("post_lu_pcwe", 32'(a_pcwe), 1);
    lit("post_lu_we", 32'({a_ifwe, a_idwe, a_exwe, a_mwwe}), 32'hF);
    drive(1, 7, 3, 7, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    lit("r0_no_stall", 32'(a_pcwe), 1);
    drive(0, 5, 5, 5, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 2, 1, 0, 0, 0, 0); #2;
    lit("bf_ifidclr", 32'(a_ifclr), 1);
    drive(1, 9, 9, 0, 1, 0, 0, 0, 0); #2;
    lit("bf_lu_ifidclr", 32'(a_ifclr), 0);
    idle();

    // bus wait acknowledged on the 4th cycle, branch flush ignored while frozen
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); #2;
    lit("mw_memwbclr", 32'(a_mwclr), 1);
    lit("mw_pcwe", 32'(a_pcwe), 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0); #2;
    lit("frz_bf_ifidclr", 32'(a_ifclr), 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0); #2;
    lit("rel_pcwe", 32'(a_pcwe), 1);
    lit("rel_memwbclr", 32'(a_mwclr), 0);
    lit("rel_bt", 32'(a_bt), 0);
    idle();

    // bus timeout with no ack
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0); #2;
      if (k == 3) lit("to_c3_bt", 32'(a_bt), 0);
      if (k == 4) lit("to_c4_bt", 32'(a_bt), 1);
      if (k == 4) lit("to_c4_pcwe", 32'(a_pcwe), 1);
      if (k == 6) lit("to_b_c6_bt", 32'(b_bt), 1);
    end
    idle(); idle();

    // ack coinciding with the timeout cycle
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0); #2;
    lit("ackto_bt", 32'(a_bt), 0);
    idle();

    // syscall beats a pending bus wait; eret during the hold is ignored
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0); #2;
    lit("exc_commit", 32'(a_exc), 1);
    lit("exc_sel", 32'(a_sel), 1);
    lit("exc_clr", 32'({a_ifclr, a_idclr, a_exclr, a_mwclr}), 32'hF);
    lit("exc_pcwe", 32'(a_pcwe), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    lit("hold_pcwe", 32'(a_pcwe), 0);
    lit("hold_excc", 32'(a_exc), 0);
    lit("hold_ifidclr", 32'(a_ifclr), 1);
    idle(); #2;
    lit("hold_done_pcwe", 32'(a_pcwe), 1);
    lit("b_hold_pcwe", 32'(b_pcwe), 0);
    idle(); idle();

    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #2;
    lit("both_sel", 32'(a_sel), 1);
    idle(); idle(); idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    lit("eret_sel", 32'(a_sel), 2);
    idle(); idle(); idle(); idle();

    // stall counter: 3-cycle bus wait + 1 load-use, then reset mid-wait
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 4, 0, 4, 0, 0, 0, 0, 0);
    idle(); #2;
    lit("perf_a", a_stall, PERF ? 32'd4 : 32'd0);
    lit("perf_b", b_stall, PERF ? 32'd4 : 32'd0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    lit("rstmid_stall", a_stall, 0);
    lit("rstmid_clr", 32'({a_ifclr, a_idclr, a_exclr, a_mwclr}), 32'hF);
    lit("rstmid_bt", 32'(a_bt), 0);
    @(posedge clk); #1 rst = 1'b1;
    idle(); idle(); idle();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
